// File: rtl/ic_number_to_hex.sv
// ic_number_to_hex
// Converts a binary IC part number (0..MAX_VALUE) into four active-low
// seven-segment digit codes using a sequential double-dabble engine.
// Start/busy/done handshake; fixed latency of 15 edges from start to done.

module ic_number_to_hex #(
  parameter bit          BLANK_LEADING = 1'b0,
  parameter int unsigned MAX_VALUE     = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] number,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  // Segment codes, active-low, bit order gfedcba
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] LEAD_RST  = BLANK_LEADING ? SEG_BLANK : SEG_0;

  // Operand width entering the engine and number of shift steps
  localparam int unsigned OP_W  = 14;
  localparam int unsigned SR_W  = 16 + OP_W;
  localparam logic [3:0]  LAST_SHIFT = 4'(OP_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_ENCODE,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;

  // {BCD thousands, hundreds, tens, units, operand}
  logic [SR_W-1:0]   r_sr;
  logic [SR_W-1:0]   w_adj;
  logic [3:0]        r_cnt;
  logic              r_ovf;

  logic [3:0]        w_d3;
  logic [3:0]        w_d2;
  logic [3:0]        w_d1;
  logic [3:0]        w_d0;
  logic              w_blank3;
  logic              w_blank2;
  logic              w_blank1;
  logic [6:0]        w_hex3;
  logic [6:0]        w_hex2;
  logic [6:0]        w_hex1;
  logic [6:0]        w_hex0;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0011000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_SHIFT;
      S_SHIFT:  if (r_cnt == LAST_SHIFT) w_next = S_ENCODE;
      S_ENCODE: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

  // Add-3 correction on every BCD nibble that is 5 or more, before the shift
  always_comb begin
    w_adj = r_sr;
    for (int unsigned i = 0; i < 4; i++) begin
      if (r_sr[OP_W + 4*i +: 4] >= 4'd5)
        w_adj[OP_W + 4*i +: 4] = r_sr[OP_W + 4*i +: 4] + 4'd3;
    end
  end

  // Conversion engine: operand latch, shift register and bit counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sr  <= {16'd0, number[OP_W-1:0]};
            r_cnt <= '0;
            r_ovf <= (number > 32'(MAX_VALUE));
          end
        end
        S_SHIFT: begin
          r_sr  <= w_adj << 1;
          r_cnt <= r_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign w_d3 = r_sr[SR_W-1   -: 4];
  assign w_d2 = r_sr[SR_W-5   -: 4];
  assign w_d1 = r_sr[SR_W-9   -: 4];
  assign w_d0 = r_sr[SR_W-13  -: 4];

  // Digit encode with optional leading-zero blanking; overflow forces dashes
  always_comb begin
    w_blank3 = BLANK_LEADING && (w_d3 == 4'd0);
    w_blank2 = w_blank3 && (w_d2 == 4'd0);
    w_blank1 = w_blank2 && (w_d1 == 4'd0);
    if (r_ovf) begin
      w_hex3 = SEG_DASH;
      w_hex2 = SEG_DASH;
      w_hex1 = SEG_DASH;
      w_hex0 = SEG_DASH;
    end else begin
      w_hex3 = w_blank3 ? SEG_BLANK : seg7(w_d3);
      w_hex2 = w_blank2 ? SEG_BLANK : seg7(w_d2);
      w_hex1 = w_blank1 ? SEG_BLANK : seg7(w_d1);
      w_hex0 = seg7(w_d0);
    end
  end

  // Output registers: updated only in ENCODE, held otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HEX3     <= LEAD_RST;
      HEX2     <= LEAD_RST;
      HEX1     <= LEAD_RST;
      HEX0     <= SEG_0;
      overflow <= 1'b0;
    end else if (r_state == S_ENCODE) begin
      HEX3     <= w_hex3;
      HEX2     <= w_hex2;
      HEX1     <= w_hex1;
      HEX0     <= w_hex0;
      overflow <= r_ovf;
    end
  end

endmodule

// File: tb/tb_ic_number_to_hex.sv
// Directed testbench for ic_number_to_hex. Two instances share inputs:
// dut0 without leading-zero blanking, dut1 with blanking enabled.

module tb_ic_number_to_hex;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0011000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] number;

  logic [6:0]  a_hex0, a_hex1, a_hex2, a_hex3;
  logic        a_busy, a_done, a_ovf;
  logic [6:0]  b_hex0, b_hex1, b_hex2, b_hex3;
  logic        b_busy, b_done, b_ovf;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  ic_number_to_hex #(.BLANK_LEADING(1'b0), .MAX_VALUE(9999)) dut0 (
    .clk(clk), .reset(reset), .start(start), .number(number),
    .HEX0(a_hex0), .HEX1(a_hex1), .HEX2(a_hex2), .HEX3(a_hex3),
    .busy(a_busy), .done(a_done), .overflow(a_ovf)
  );

  ic_number_to_hex #(.BLANK_LEADING(1'b1), .MAX_VALUE(9999)) dut1 (
    .clk(clk), .reset(reset), .start(start), .number(number),
    .HEX0(b_hex0), .HEX1(b_hex1), .HEX2(b_hex2), .HEX3(b_hex3),
    .busy(b_busy), .done(b_done), .overflow(b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] hx(input logic [6:0] h3, input logic [6:0] h2,
                                     input logic [6:0] h1, input logic [6:0] h0);
    return {4'd0, h3, h2, h1, h0};
  endfunction

  // Pulse start for one edge with the given number; returns after edge 0 + #1
  task automatic kick(input logic [31:0] num);
    @(negedge clk);
    number = num;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  // Count edges until dut0 asserts done; 0 means the bound expired
  task automatic wait_done(output int edges);
    edges = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (a_done) begin
        edges = i;
        break;
      end
    end
  endtask

  // Count done pulses of either instance over n edges
  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (a_done || b_done) cnt++;
    end
  endtask

  task automatic after_done();
    @(posedge clk);
    #1;
    check("done_one_cycle", {31'd0, a_done}, 32'd0);
    check("busy_idle",      {31'd0, a_busy}, 32'd0);
  endtask

  int e;
  int c;

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    number = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hex0", hx(a_hex3, a_hex2, a_hex1, a_hex0), hx(S0, S0, S0, S0));
    check("rst_hex1", hx(b_hex3, b_hex2, b_hex1, b_hex0), hx(SB, SB, SB, S0));
    check("rst_flags", {29'd0, a_busy, a_done, a_ovf}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 7400: latency and digits
    kick(32'd7400);
    check("busy_after_start", {31'd0, a_busy}, 32'd1);
    wait_done(e);
    check("lat_7400", e, 32'd15);
    check("hex_7400", hx(a_hex3, a_hex2, a_hex1, a_hex0), hx(S7, S4, S0, S0));
    check("ovf_7400", {31'd0, a_ovf}, 32'd0);
    check("busy_in_done", {31'd0, a_busy}, 32'd1);
    after_done();

    // Overflow boundary and full-scale
    kick(32'd10000);
    wait_done(e);
    check("hex_10000", hx(a_hex3, a_hex2, a_hex1, a_hex0), hx(SD, SD, SD, SD));
    check("ovf_10000", {31'd0, a_ovf}, 32'd1);
    check("hex_10000_blk", hx(b_hex3, b_hex2, b_hex1, b_hex0), hx(SD, SD, SD, SD));
    after_done();

    kick(32'hFFFF_FFFF);
    wait_done(e);
    check("hex_ffff", hx(a_hex3, a_hex2, a_hex1, a_hex0), hx(SD, SD, SD, SD));
    check("ovf_ffff", {31'd0, a_ovf}, 32'd1);
    after_done();

    kick(32'd0);
    wait_done(e);
    check("hex_zero", hx(a_hex3, a_hex2, a_hex1, a_hex0), hx(S0, S0, S0, S0));
    check("ovf_zero", {31'd0, a_ovf}, 32'd0);
    check("hex_zero_blk", hx(b_hex3, b_hex2, b_hex1, b_hex0), hx(SB, SB, SB, S0));
    after_done();

    // Reset mid-SHIFT with overflow previously set
    kick(32'd10000);
    wait_done(e);
    check("ovf_set_again", {31'd0, a_ovf}, 32'd1);
    after_done();
    kick(32'd7400);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, a_busy}, 32'd0);
    check("abort_ovf",  {31'd0, a_ovf},  32'd0);
    check("abort_hex",  hx(a_hex3, a_hex2, a_hex1, a_hex0), hx(S0, S0, S0, S0));
    @(negedge clk);
    reset = 1'b0;
    count_dones(20, c);
    check("abort_no_done", c, 32'd0);

    // Back-to-back with start held high; number changes after acceptance
    @(negedge clk);
    number = 32'd4011;
    start  = 1'b1;
    @(posedge clk);
    #1;
    number = 32'd9999;
    wait_done(e);
    check("lat_4011", e, 32'd15);
    check("hex_4011", hx(a_hex3, a_hex2, a_hex1, a_hex0), hx(S4, S0, S1, S1));
    e = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 8)
        check("hold_during_shift", hx(a_hex3, a_hex2, a_hex1, a_hex0), hx(S4, S0, S1, S1));
      if (a_done) begin
        e = i;
        break;
      end
    end
    start = 1'b0;
    check("b2b_spacing", e, 32'd17);
    check("hex_9999", hx(a_hex3, a_hex2, a_hex1, a_hex0), hx(S9, S9, S9, S9));
    after_done();

    // Start while busy is ignored; number change after acceptance ignored
    kick(32'd1234);
    @(negedge clk);
    @(negedge clk);
    number = 32'd5678;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    wait_done(e);
    check("lat_busy_start", e, 32'd13);
    check("hex_1234", hx(a_hex3, a_hex2, a_hex1, a_hex0), hx(S1, S2, S3, S4));
    count_dones(20, c);
    check("single_done", c, 32'd0);

    // Leading-zero blanking
    kick(32'd32);
    wait_done(e);
    check("hex_32_blk", hx(b_hex3, b_hex2, b_hex1, b_hex0), hx(SB, SB, S3, S2));
    check("hex_32",     hx(a_hex3, a_hex2, a_hex1, a_hex0), hx(S0, S0, S3, S2));
    after_done();

    kick(32'd0);
    wait_done(e);
    check("hex_0_blk", hx(b_hex3, b_hex2, b_hex1, b_hex0), hx(SB, SB, SB, S0));
    after_done();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
